dm_sbus_slave: RTL and testbench

DM_SBUS_SLAVE -- requirements
Module: dm_sbus_slave

---
 rtl/dm_sbus_slave_pkg.sv | 40 ++++
 rtl/dm_sbus_slave_mem.sv | 47 ++++
 rtl/dm_sbus_slave.sv | 149 ++++++++++++++
 tb/tb_dm_sbus_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sbus_slave_pkg.sv
// Shared definitions for the debug-module system-bus slave.
//   sbus_state_e  : transaction FSM states.
//   sbus_err_e    : response error classification captured at grant.
//   sbus_classify : maps a granted request onto its response error type.
package dm_sbus_slave_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_RESP     = 2'd2
    } sbus_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_DECODE = 2'd1,
        ERR_OTHER  = 2'd2
    } sbus_err_e;

    // An injected error wins outright (it is meant to force r_other_err).
    // Otherwise an out-of-window address beats a misaligned one.
    // end_addr is 33 bits so a window touching 4 GiB does not wrap.
    function automatic sbus_err_e sbus_classify(input logic [31:0] add,
                                                input logic [31:0] base,
                                                input logic [32:0] end_addr,
                                                input logic        inject);
        if (inject) begin
            return ERR_OTHER;
        end
        if ((add < base) || ({1'b0, add} >= end_addr)) begin
            return ERR_DECODE;
        end
        if (add[1:0] != 2'b00) begin
            return ERR_OTHER;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dm_sbus_slave_mem.sv
// Single-port word memory with byte-lane writes and a registered read.
//   clk_i   : clock
//   en_i    : access enable for this cycle
//   we_i    : 1 = write selected lanes, 0 = read whole word into rdata_o
//   be_i    : byte-lane enables for writes
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : word captured by the most recent read; holds until the next read
// Contents are deliberately not reset.
module dm_sbus_slave_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en_i && !we_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        if (en_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_sbus_slave.sv
// System-bus slave backed by a local word memory.
//   clk_i / rst_i        : clock, synchronous active-high reset
//   slave_req_i          : master request; add/we/wdata/be are sampled in the grant cycle
//   err_inject_i         : arms a forced r_other_err for the next granted transaction
//   slave_gnt_o          : request accepted this cycle (combinational)
//   slave_r_valid_o      : one-cycle response strobe, RESP_LATENCY cycles after grant
//   slave_r_err_o        : address outside the memory window
//   slave_r_other_err_o  : misaligned address or injected error
//   slave_r_rdata_o      : read data; zero unless a clean read is responding
// Handshake: a transaction is accepted in the cycle where slave_req_i and
// slave_gnt_o are both high; exactly one slave_r_valid_o pulse follows per
// accepted transaction, and no new grant is given until that pulse is done.
module dm_sbus_slave
    import dm_sbus_slave_pkg::*;
#(
    parameter int          MEM_WORDS    = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          GNT_DELAY    = 0,
    parameter int          RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slave_req_i,
    input  logic [31:0] slave_add_i,
    input  logic        slave_we_i,
    input  logic [31:0] slave_wdata_i,
    input  logic [3:0]  slave_be_i,
    input  logic        err_inject_i,
    output logic        slave_gnt_o,
    output logic        slave_r_valid_o,
    output logic        slave_r_err_o,
    output logic        slave_r_other_err_o,
    output logic [31:0] slave_r_rdata_o
);

    localparam int              AW        = $clog2(MEM_WORDS);
    localparam logic [32:0]     END_ADDR  = {1'b0, BASE_ADDR} + 33'(MEM_WORDS * 4);
    // Counters are loaded with "cycles still to wait after this one".
    localparam logic [CNT_W-1:0] GNT_LOAD  = CNT_W'(GNT_DELAY - 1);
    localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_LATENCY - 1);

    sbus_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inject_q, inject_d;
    sbus_err_e        err_q, err_d;
    logic             we_q, we_d;

    logic        gnt;
    logic        gnt_ok;
    logic        r_valid;
    sbus_err_e   err_now;
    logic [31:0] offset;
    logic [31:0] mem_rdata;

    assign err_now = sbus_classify(slave_add_i, BASE_ADDR, END_ADDR, inject_q | err_inject_i);
    assign offset  = slave_add_i - BASE_ADDR;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        we_d     = we_q;
        inject_d = inject_q | err_inject_i;
        gnt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slave_req_i) begin
                    if (GNT_DELAY == 0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = GNT_LOAD;
                        state_d = ST_WAIT_GNT;
                    end
                end
            end
            ST_WAIT_GNT: begin
                if (!slave_req_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (gnt) begin
            state_d  = ST_RESP;
            cnt_d    = RESP_LOAD;
            err_d    = err_now;
            we_d     = slave_we_i;
            inject_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            inject_q <= 1'b0;
            err_q    <= ERR_NONE;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inject_q <= inject_d;
            err_q    <= err_d;
            we_q     <= we_d;
        end
    end

    // Reset suppresses both a grant and a pending response in the same cycle.
    assign gnt_ok  = gnt && !rst_i;
    assign r_valid = (state_q == ST_RESP) && (cnt_q == '0) && !rst_i;

    // Errored transactions never touch memory.
    dm_sbus_slave_mem #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (gnt_ok && (err_now == ERR_NONE)),
        .we_i    (slave_we_i),
        .be_i    (slave_be_i),
        .addr_i  (AW'(offset >> 2)),
        .wdata_i (slave_wdata_i),
        .rdata_o (mem_rdata)
    );

    assign slave_gnt_o         = gnt_ok;
    assign slave_r_valid_o     = r_valid;
    assign slave_r_err_o       = r_valid && (err_q == ERR_DECODE);
    assign slave_r_other_err_o = r_valid && (err_q == ERR_OTHER);
    assign slave_r_rdata_o     = (r_valid && (err_q == ERR_NONE) && !we_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dm_sbus_slave.sv
module tb_dm_sbus_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, inj0, inj1;
  logic        we;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt0, valid0, err0, oerr0;
  logic [31:0] rdata0;
  logic        gnt1, valid1, err1, oerr1;
  logic [31:0] rdata1;

  // dut0: default timing; dut1: GNT_DELAY=3, RESP_LATENCY=2
  dm_sbus_slave dut0 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req0), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be), .err_inject_i(inj0),
    .slave_gnt_o(gnt0), .slave_r_valid_o(valid0), .slave_r_err_o(err0),
    .slave_r_other_err_o(oerr0), .slave_r_rdata_o(rdata0)
  );

  dm_sbus_slave #(.GNT_DELAY(3), .RESP_LATENCY(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req1), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be), .err_inject_i(inj1),
    .slave_gnt_o(gnt1), .slave_r_valid_o(valid1), .slave_r_err_o(err1),
    .slave_r_other_err_o(oerr1), .slave_r_rdata_o(rdata1)
  );

  int          sel;
  logic        gnt_s, valid_s, err_s, oerr_s;
  logic [31:0] rdata_s;

  always_comb begin
    if (sel == 0) begin
      gnt_s = gnt0; valid_s = valid0; err_s = err0; oerr_s = oerr0; rdata_s = rdata0;
    end else begin
      gnt_s = gnt1; valid_s = valid1; err_s = err1; oerr_s = oerr1; rdata_s = rdata1;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sbus_txn(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rd, output logic e, output logic oe,
                          output int gw, output int lat);
    logic got_gnt;
    sel = s;
    rd = 32'h0; e = 1'b0; oe = 1'b0; gw = 0; lat = 0;
    @(posedge clk); #1;
    we = w; add = a; wdata = d; be = b;
    if (s == 0) req0 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    while (!gnt_s && gw < 20) begin
      @(negedge clk);
      gw++;
    end
    got_gnt = gnt_s;
    check("gnt_seen", 32'(gnt_s), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (got_gnt) begin
      lat = 1;
      @(negedge clk);
      while (!valid_s && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("rvalid_seen", 32'(valid_s), 32'd1);
      rd = rdata_s; e = err_s; oe = oerr_s;
      @(negedge clk);
      check("rvalid_one_cycle", 32'(valid_s), 32'd0);
      check("rdata_idle_zero", rdata_s, 32'h0);
    end
  endtask

  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic exp_err, input logic exp_oerr,
                          input string tag);
    logic [31:0] rd;
    logic        e, oe;
    int          gw, lat;
    sbus_txn(s, 1'b1, a, d, b, rd, e, oe, gw, lat);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_oerr"}, 32'(oe), 32'(exp_oerr));
    check({tag, "_gnt_wait"}, gw, (s == 0) ? 32'd0 : 32'd3);
    check({tag, "_lat"}, lat, (s == 0) ? 32'd1 : 32'd2);
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input logic [31:0] exp_data,
                         input logic exp_err, input logic exp_oerr, input string tag);
    logic [31:0] rd;
    logic        e, oe;
    int          gw, lat;
    exp_q.push_back(exp_data);
    sbus_txn(s, 1'b0, a, 32'h0, 4'hF, rd, e, oe, gw, lat);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_oerr"}, 32'(oe), 32'(exp_oerr));
    check({tag, "_gnt_wait"}, gw, (s == 0) ? 32'd0 : 32'd3);
    check({tag, "_lat"}, lat, (s == 0) ? 32'd1 : 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] gpat, vpat;
    int         seen;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; inj0 = 1'b0; inj1 = 1'b0;
    we = 1'b0; add = 32'h0; wdata = 32'h0; be = 4'h0; sel = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt0", 32'(gnt0), 32'd0);
    check("reset_valid0", 32'(valid0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_valid0", 32'(valid0), 32'd0);
    check("post_reset_rdata0", rdata0, 32'h0);
    check("post_reset_err0", 32'({err0, oerr0}), 32'd0);
    check("post_reset_valid1", 32'(valid1), 32'd0);

    // full-word write and readback
    do_write(0, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, "wr_1004");
    do_read (0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd_1004");

    // partial-lane write
    do_write(0, 32'h0000_1008, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, "wr_1008_ones");
    do_write(0, 32'h0000_1008, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, "wr_1008_be5");
    do_read (0, 32'h0000_1008, 32'hFF22_FF44, 1'b0, 1'b0, "rd_1008");

    // decode and alignment errors
    do_read (0, 32'h0000_0FFC, 32'h0, 1'b1, 1'b0, "rd_below");
    do_read (0, 32'h0000_1400, 32'h0, 1'b1, 1'b0, "rd_above");
    do_read (0, 32'h0000_1002, 32'h0, 1'b0, 1'b1, "rd_misaligned");
    do_read (0, 32'h0000_1401, 32'h0, 1'b1, 1'b0, "rd_above_misal");

    // last word in the window
    do_write(0, 32'h0000_13FC, 32'h13FC_13FC, 4'hF, 1'b0, 1'b0, "wr_last");
    do_read (0, 32'h0000_13FC, 32'h13FC_13FC, 1'b0, 1'b0, "rd_last");

    // errored writes must not alias into memory
    do_write(0, 32'h0000_1000, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, "wr_1000");
    do_write(0, 32'h0000_1400, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, "wr_above");
    do_read (0, 32'h0000_1000, 32'h0BAD_F00D, 1'b0, 1'b0, "rd_1000_kept");
    do_write(0, 32'h0000_1006, 32'h0000_0000, 4'hF, 1'b0, 1'b1, "wr_misaligned");
    do_write(0, 32'h0000_1004, 32'h0000_0000, 4'h0, 1'b0, 1'b0, "wr_be0");
    do_read (0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd_1004_kept");

    // injected error
    do_write(0, 32'h0000_1010, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0, "wr_1010");
    @(posedge clk); #1; inj0 = 1'b1;
    @(posedge clk); #1; inj0 = 1'b0;
    do_write(0, 32'h0000_1010, 32'h1234_5678, 4'hF, 1'b0, 1'b1, "wr_1010_inj");
    do_read (0, 32'h0000_1010, 32'hA5A5_A5A5, 1'b0, 1'b0, "rd_1010_clean");

    // back-to-back reads with req held: one transaction every 2 cycles
    sel = 0;
    @(posedge clk); #1;
    we = 1'b0; add = 32'h0000_1004; be = 4'hF; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gpat[i] = gnt0;
      vpat[i] = valid0;
      if (i == 5) check("b2b_rdata", rdata0, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1; req0 = 1'b0;
    check("b2b_gnt_pattern", 32'(gpat), 32'h15);
    check("b2b_valid_pattern", 32'(vpat), 32'h2A);
    @(negedge clk);

    // reset during RESP on dut0
    do_write(0, 32'h0000_1018, 32'h0000_0077, 4'hF, 1'b0, 1'b0, "wr_1018");
    @(posedge clk); #1;
    we = 1'b0; add = 32'h0000_1018; be = 4'hF; req0 = 1'b1;
    @(negedge clk);
    check("rst_resp_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_resp_valid0", 32'(valid0), 32'd0);
    check("rst_resp_rdata0", rdata0, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_resp_after_valid0", 32'(valid0), 32'd0);
    do_read (0, 32'h0000_1018, 32'h0000_0077, 1'b0, 1'b0, "rd_1018_after_rst");
    do_read (0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd_1004_after_rst");

    // dut1: delayed grant and longer latency
    do_write(1, 32'h0000_1020, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, "d1_wr_1020");
    do_read (1, 32'h0000_1020, 32'hCAFE_F00D, 1'b0, 1'b0, "d1_rd_1020");

    // dut1: request dropped before grant
    sel = 1;
    @(posedge clk); #1;
    we = 1'b1; add = 32'h0000_1020; wdata = 32'h0; be = 4'hF; req1 = 1'b1;
    seen = 0;
    @(negedge clk);
    if (gnt1 || valid1) seen++;
    @(posedge clk); #1; req1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt1 || valid1) seen++;
    end
    check("d1_abort_no_activity", seen, 32'd0);
    do_read (1, 32'h0000_1020, 32'hCAFE_F00D, 1'b0, 1'b0, "d1_rd_after_abort");

    // dut1: reset in the first RESP cycle suppresses the response
    sel = 1;
    @(posedge clk); #1;
    we = 1'b0; add = 32'h0000_1020; be = 4'hF; req1 = 1'b1;
    seen = 0;
    @(negedge clk);
    while (!gnt1 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("d1_rst_gnt_wait", seen, 32'd3);
    @(posedge clk); #1;
    req1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("d1_rst_valid", 32'(valid1), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid1 || err1 || oerr1 || (rdata1 != 32'h0)) seen++;
    end
    check("d1_rst_no_response", seen, 32'd0);
    do_read (1, 32'h0000_1020, 32'hCAFE_F00D, 1'b0, 1'b0, "d1_rd_after_rst");

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
